// File: rtl/write_sched_pkg.sv
// Shared types and constants for the two-requester write scheduler.
package write_sched_pkg;

    localparam int NUM_REQ = 2;

    // IDLE: arbitrate | GO: pulse ctl_go | RUN: stream words | FIN: pulse req_done
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] req_mask(input logic id);
        req_mask     = '0;
        req_mask[id] = 1'b1;
    endfunction

endpackage

// File: rtl/write_sched_if.sv
// Requester and write-master signals of the scheduler; slave is the scheduler side.
interface write_sched_if #(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATAWIDTH    = 32
);
    import write_sched_pkg::*;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*ADDRESSWIDTH-1:0] req_base;
    logic [NUM_REQ*ADDRESSWIDTH-1:0] req_length;
    logic [NUM_REQ-1:0]              req_ack;
    logic [NUM_REQ-1:0]              req_done;
    logic [NUM_REQ-1:0]              req_wr;
    logic [NUM_REQ*DATAWIDTH-1:0]    req_data;
    logic [NUM_REQ-1:0]              req_full;
    logic                            ctl_go;
    logic [ADDRESSWIDTH-1:0]         ctl_write_base;
    logic [ADDRESSWIDTH-1:0]         ctl_write_length;
    logic                            ctl_fixed_location;
    logic                            ctl_done;
    logic                            user_write_buffer;
    logic [DATAWIDTH-1:0]            user_buffer_data;
    logic                            user_buffer_full;
    logic                            busy;
    logic                            grant_id;

    modport slave (
        input  req_valid, req_base, req_length, req_wr, req_data, ctl_done, user_buffer_full,
        output req_ack, req_done, req_full, ctl_go, ctl_write_base, ctl_write_length,
               ctl_fixed_location, user_write_buffer, user_buffer_data, busy, grant_id
    );

    modport master (
        output req_valid, req_base, req_length, req_wr, req_data, ctl_done, user_buffer_full,
        input  req_ack, req_done, req_full, ctl_go, ctl_write_base, ctl_write_length,
               ctl_fixed_location, user_write_buffer, user_buffer_data, busy, grant_id
    );

endinterface

// File: rtl/write_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester holding priority.
module rr_arb2
    import write_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_take,
    output logic               o_any,
    output logic               o_gid
);

    logic r_prio;
    logic w_gid;

    assign w_gid = i_req[r_prio] ? r_prio : ~r_prio;
    assign o_gid = w_gid;
    assign o_any = |i_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prio <= 1'b0;
        end else if (i_take && o_any) begin
            r_prio <= ~w_gid;
        end
    end

endmodule

// File: rtl/write_sched.sv
// Grants one of two requesters to the write master and forwards its data stream,
// counting words so the master never receives more than the granted length.
module write_sched
    import write_sched_pkg::*;
#(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATAWIDTH    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    write_sched_if.slave  bus
);

    state_t                  r_state;
    logic                    r_gid;
    logic [ADDRESSWIDTH-1:0] r_base;
    logic [ADDRESSWIDTH-1:0] r_len;
    logic [ADDRESSWIDTH-1:0] r_wcount;
    logic                    r_ctl_go;
    logic [NUM_REQ-1:0]      r_done;

    logic                    w_any;
    logic                    w_gid;
    logic                    w_take;
    logic                    w_xfer;
    logic                    w_at_len;
    logic                    w_push;
    logic                    w_full_g;
    logic [ADDRESSWIDTH-1:0] w_sel_base;
    logic [ADDRESSWIDTH-1:0] w_sel_len;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (bus.req_valid),
        .i_take  (w_take),
        .o_any   (w_any),
        .o_gid   (w_gid)
    );

    assign w_take     = (r_state == ST_IDLE) && w_any;
    assign w_sel_base = w_gid ? bus.req_base[ADDRESSWIDTH +: ADDRESSWIDTH]
                              : bus.req_base[0 +: ADDRESSWIDTH];
    assign w_sel_len  = w_gid ? bus.req_length[ADDRESSWIDTH +: ADDRESSWIDTH]
                              : bus.req_length[0 +: ADDRESSWIDTH];

    assign w_xfer   = (r_state == ST_GO) || (r_state == ST_RUN);
    assign w_at_len = (r_wcount == r_len);
    assign w_push   = w_xfer && bus.req_wr[r_gid] && !bus.user_buffer_full && (r_wcount < r_len);
    assign w_full_g = bus.user_buffer_full || w_at_len;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_gid    <= 1'b0;
            r_base   <= '0;
            r_len    <= '0;
            r_wcount <= '0;
            r_ctl_go <= 1'b0;
            r_done   <= '0;
        end else begin
            r_ctl_go <= 1'b0;
            r_done   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gid    <= w_gid;
                        r_base   <= w_sel_base;
                        r_len    <= w_sel_len;
                        r_wcount <= '0;
                        if (w_sel_len == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= req_mask(w_gid);
                        end else begin
                            r_state  <= ST_GO;
                            r_ctl_go <= 1'b1;
                        end
                    end
                end
                // ctl_done still reflects the previous length here, so it is not looked at
                ST_GO: begin
                    r_state <= ST_RUN;
                    if (w_push) r_wcount <= r_wcount + ADDRESSWIDTH'(1);
                end
                ST_RUN: begin
                    if (w_push) r_wcount <= r_wcount + ADDRESSWIDTH'(1);
                    if (bus.ctl_done && w_at_len) begin
                        r_state <= ST_FIN;
                        r_done  <= req_mask(r_gid);
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ack            = w_take ? req_mask(w_gid) : '0;
    assign bus.req_done           = r_done;
    assign bus.req_full           = !w_xfer ? 2'b11 : (r_gid ? {w_full_g, 1'b1} : {1'b1, w_full_g});
    assign bus.ctl_go             = r_ctl_go;
    assign bus.ctl_write_base     = r_base;
    assign bus.ctl_write_length   = r_len;
    assign bus.ctl_fixed_location = 1'b0;
    assign bus.user_write_buffer  = w_push;
    assign bus.user_buffer_data   = !w_xfer ? '0 : (r_gid ? bus.req_data[DATAWIDTH +: DATAWIDTH]
                                                          : bus.req_data[0 +: DATAWIDTH]);
    assign bus.busy               = (r_state != ST_IDLE);
    assign bus.grant_id           = r_gid;

endmodule

// File: tb/tb_write_sched.sv
// Directed bench for write_sched: a per-cycle behavioural model plus literal checks per scenario.
module tb_write_sched;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic reset_n;

    write_sched_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus ();

    write_sched #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Write master: ctl_done while no words remain outstanding.
    logic [AW-1:0] wm_rem;
    always @(posedge clk) begin
        if (!reset_n)               wm_rem <= '0;
        else if (bus.ctl_go)        wm_rem <= bus.ctl_write_length - (bus.user_write_buffer ? 1 : 0);
        else if (bus.user_write_buffer) wm_rem <= wm_rem - 1;
    end
    assign bus.ctl_done = (wm_rem == '0);

    // Requester data sources: push left[i] words, optionally ignoring req_full.
    int          left [2] = '{0, 0};
    bit          ign  [2] = '{0, 0};
    logic [31:0] dval [2] = '{32'hA000_0000, 32'hB000_0000};
    initial begin
        bit taken [2];
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) taken[i] = bus.req_wr[i] && (ign[i] || !bus.req_full[i]);
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (taken[i]) begin
                    left[i]--;
                    dval[i]++;
                end
                bus.req_wr[i]         = (left[i] > 0);
                bus.req_data[i*DW +: DW] = dval[i];
            end
        end
    end

    // Cycle counter and event monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ack_log[$];
    int ack_cnt, ack_cyc, go_cnt, push_cnt, last_push_cyc, done_cnt, done_cyc, done_id;
    logic [AW-1:0] go_base, go_len;

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) if (bus.req_ack[i]) begin
                ack_log.push_back(i);
                ack_cnt++;
                ack_cyc = cyc;
            end
            if (bus.ctl_go) begin
                go_cnt++;
                go_base = bus.ctl_write_base;
                go_len  = bus.ctl_write_length;
            end
            if (bus.user_write_buffer) begin
                push_cnt++;
                last_push_cyc = cyc;
            end
            for (int i = 0; i < 2; i++) if (bus.req_done[i]) begin
                done_cnt++;
                done_cyc = cyc;
                done_id  = i;
            end
        end
    end

    task automatic clr();
        ack_log.delete();
        ack_cnt = 0; go_cnt = 0; push_cnt = 0; done_cnt = 0;
        ack_cyc = -1; done_cyc = -1; last_push_cyc = -1; done_id = -1;
    endtask

    // Behavioural model: phase 0 idle, 1 go, 2 run, 3 fin
    int            m_phase = 0;
    bit            m_known = 0;
    bit            m_prio, m_gid;
    logic [AW-1:0] m_base, m_len, m_words;

    always @(negedge clk) begin
        logic [1:0]    e_ack, e_done, e_full;
        logic          e_push;
        bit            g;
        if (!reset_n) begin
            m_phase = 0; m_prio = 0; m_gid = 0;
            m_base = '0; m_len = '0; m_words = '0;
            m_known = 1;
        end else if (m_known) begin
            e_ack = 2'b00; e_done = 2'b00; e_full = 2'b11; e_push = 1'b0; g = 0;
            if (m_phase == 0 && bus.req_valid != 2'b00) begin
                g = bus.req_valid[m_prio] ? m_prio : !m_prio;
                e_ack[g] = 1'b1;
            end
            if (m_phase == 1 || m_phase == 2) begin
                e_push = bus.req_wr[m_gid] && !bus.user_buffer_full && (m_words < m_len);
                e_full[m_gid] = bus.user_buffer_full || (m_words == m_len);
            end
            if (m_phase == 3) e_done[m_gid] = 1'b1;

            chk("ack",    bus.req_ack,            e_ack);
            chk("done",   bus.req_done,           e_done);
            chk("full",   bus.req_full,           e_full);
            chk("busy",   bus.busy,               m_phase != 0);
            chk("go",     bus.ctl_go,             m_phase == 1);
            chk("gid",    bus.grant_id,           m_gid);
            chk("base",   bus.ctl_write_base,     m_base);
            chk("len",    bus.ctl_write_length,   m_len);
            chk("fixed",  bus.ctl_fixed_location, 1'b0);
            chk("push",   bus.user_write_buffer,  e_push);
            if (e_push) chk("data", bus.user_buffer_data, bus.req_data[m_gid*DW +: DW]);

            case (m_phase)
                0: if (e_ack != 2'b00) begin
                    m_gid   = g;
                    m_prio  = !g;
                    m_base  = bus.req_base[g*AW +: AW];
                    m_len   = bus.req_length[g*AW +: AW];
                    m_words = '0;
                    m_phase = (m_len == 0) ? 3 : 1;
                end
                1: begin
                    m_phase = 2;
                    m_words += e_push;
                end
                2: begin
                    if (bus.ctl_done && m_words == m_len) m_phase = 3;
                    m_words += e_push;
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic set_req(input int id, input logic [31:0] base, input logic [31:0] len);
        bus.req_base[id*AW +: AW]   = base;
        bus.req_length[id*AW +: AW] = len;
        bus.req_valid[id]           = 1'b1;
    endtask

    task automatic wait_acks(input logic [1:0] mask);
        logic [1:0] pending, got;
        pending = mask;
        for (int k = 0; k < 200 && pending != 2'b00; k++) begin
            @(negedge clk);
            got = bus.req_ack & pending;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & ~got;
            pending       = pending & ~got;
        end
        if (pending != 2'b00) chk("ack_timeout", pending, 2'b00);
    endtask

    task automatic wait_done(input int n);
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= n) ok = 1;
        end
        if (!ok) chk("done_timeout", done_cnt, n);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pushes(input int n);
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (push_cnt >= n) ok = 1;
        end
        if (!ok) chk("push_timeout", push_cnt, n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        reset_n = 1'b0;
        bus.req_valid = '0; bus.req_base = '0; bus.req_length = '0;
        bus.req_wr = '0; bus.req_data = '0; bus.user_buffer_full = 1'b0;
        clr();
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  bus.busy,             1'b0);
        chk("rst_full",  bus.req_full,         2'b11);
        chk("rst_len",   bus.ctl_write_length, 32'h0);
        chk("rst_go",    bus.ctl_go,           1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Simultaneous requests after reset: requester 0 first
        clr();
        left[0] = 2; left[1] = 2;
        set_req(0, 32'h200, 2);
        set_req(1, 32'h300, 2);
        wait_acks(2'b11);
        wait_done(2);
        chk("sim_first",  ack_log[0], 0);
        chk("sim_second", ack_log[1], 1);
        chk("sim_gos",    go_cnt,     2);
        chk("sim_pushes", push_cnt,   4);

        // Single request, base 0x100, length 4
        clr();
        left[0] = 4;
        set_req(0, 32'h100, 4);
        wait_acks(2'b01);
        wait_done(1);
        chk("one_acks",    ack_cnt,  1);
        chk("one_gos",     go_cnt,   1);
        chk("one_base",    go_base,  32'h100);
        chk("one_len",     go_len,   32'h4);
        chk("one_pushes",  push_cnt, 4);
        chk("one_latency", done_cyc - last_push_cyc, 2);
        chk("one_done_id", done_id,  0);

        // Repeat simultaneous: requester 0 was served last, so requester 1 first
        clr();
        left[0] = 2; left[1] = 2;
        set_req(0, 32'h500, 2);
        set_req(1, 32'h600, 2);
        wait_acks(2'b11);
        wait_done(2);
        chk("rep_first",  ack_log[0], 1);
        chk("rep_second", ack_log[1], 0);

        // Zero length on requester 1
        clr();
        set_req(1, 32'h400, 0);
        wait_acks(2'b10);
        wait_done(1);
        chk("zero_acks",  ack_cnt, 1);
        chk("zero_gos",   go_cnt,  0);
        chk("zero_lat",   done_cyc - ack_cyc, 1);
        chk("zero_id",    done_id, 1);

        // Back-pressure for 5 cycles mid-transfer
        clr();
        left[0] = 4;
        set_req(0, 32'h700, 4);
        wait_acks(2'b01);
        wait_pushes(2);
        bus.user_buffer_full = 1'b1;
        p = push_cnt;
        repeat (5) @(negedge clk);
        chk("bp_blocked", push_cnt - p, 0);
        @(posedge clk);
        #1 bus.user_buffer_full = 1'b0;
        wait_done(1);
        chk("bp_pushes", push_cnt, 4);

        // Over-push: 6 writes offered for length 4
        clr();
        set_req(0, 32'h800, 4);
        wait_acks(2'b01);
        ign[0] = 1; left[0] = 6;
        wait_done(1);
        chk("over_pushes", push_cnt, 4);
        repeat (8) @(posedge clk);
        #1;
        ign[0] = 0; left[0] = 0;
        chk("over_gos", go_cnt, 1);

        // Reset in the middle of RUN
        clr();
        left[0] = 8;
        set_req(0, 32'h900, 8);
        wait_acks(2'b01);
        wait_pushes(2);
        reset_n = 1'b0;
        left[0] = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("mrst_busy", bus.busy,     1'b0);
        chk("mrst_full", bus.req_full, 2'b11);
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_nodone", done_cnt, 0);
        clr();
        left[1] = 2;
        set_req(1, 32'hA00, 2);
        wait_acks(2'b10);
        wait_done(1);
        chk("post_done_id", done_id,  1);
        chk("post_pushes",  push_cnt, 2);
        chk("post_base",    go_base,  32'hA00);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
